sad_accum_min: RTL

Downstream consumer of the PE array in the DMT motion-estimation datapath. Each cycle it takes the `abs_out` values of one row of NUM_PE processing elements and sums them through a registered adder tree. It accumulates the row sums over ROWS beats to form the SAD of one candidate motion vector. It tracks the minimum SAD and its candidate index over NUM_CAND candidates and reports the best match when the search completes.

---
 rtl/sad_accum_min_pkg.sv | 25 ++
 rtl/sad_accum_min_adder_tree.sv | 43 ++++
 rtl/sad_accum_min.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sad_accum_min_pkg.sv
// Shared motion-estimation package.
// Holds the default pixel width, the helpers that derive the SAD and
// candidate-index widths, and the sequencing state type for sad_accum_min.
package sad_accum_min_pkg;

  localparam int unsigned ME_PIXEL = 8;

  // A candidate's SAD sums num_pe*rows absolute differences of pixel bits each.
  function automatic int unsigned sad_width(input int unsigned pixel,
                                            input int unsigned num_pe,
                                            input int unsigned rows);
    return pixel + $clog2(num_pe * rows);
  endfunction

  function automatic int unsigned mv_width(input int unsigned num_cand);
    return (num_cand > 1) ? $clog2(num_cand) : 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } me_state_t;

endpackage

// File: rtl/sad_accum_min_adder_tree.sv
// sad_adder_tree: sums one row of NUM_PE unsigned PIXEL-wide absolute
// differences and registers the result, with a valid that travels alongside.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   data        packed PE values, PE0 in the LSBs
//   data_valid  data holds a beat this cycle
//   sum         registered row sum (PIXEL+log2(NUM_PE) bits)
//   sum_valid   sum holds a beat
module sad_adder_tree
  import sad_accum_min_pkg::*;
#(
  parameter int unsigned PIXEL  = ME_PIXEL,
  parameter int unsigned NUM_PE = 8,
  parameter int unsigned TREE_W = PIXEL + $clog2(NUM_PE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PE*PIXEL-1:0] data,
  input  logic                    data_valid,
  output logic [TREE_W-1:0]       sum,
  output logic                    sum_valid
);

  logic [TREE_W-1:0] sum_c;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      sum_c = sum_c + TREE_W'(data[i*PIXEL +: PIXEL]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= data_valid;
      if (data_valid) sum <= sum_c;
    end
  end

endmodule

// File: rtl/sad_accum_min.sv
// sad_accum_min: accumulates row sums from the PE array into per-candidate
// SADs and tracks the minimum SAD and its candidate index over a search.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   search_start        pulse, (re)starts a search from any state
//   abs_valid, abs_in   one row beat of packed PE abs values
//   sad_valid/out/mv    pulse with the SAD and index of a finished candidate
//   busy                search in progress, including pipeline drain
//   done                pulse, best_sad/best_mv are final
//   best_sad, best_mv   running minimum and its candidate index
//
// state    | meaning
// ST_IDLE  | waiting for search_start
// ST_ACCUM | accepting beats, counting rows and candidates
// ST_DRAIN | last beat taken, waiting for the final compare
module sad_accum_min
  import sad_accum_min_pkg::*;
#(
  parameter int unsigned PIXEL    = ME_PIXEL,
  parameter int unsigned NUM_PE   = 8,
  parameter int unsigned ROWS     = 8,
  parameter int unsigned NUM_CAND = 64,
  parameter int unsigned SAD_W    = sad_width(PIXEL, NUM_PE, ROWS),
  parameter int unsigned MV_W     = mv_width(NUM_CAND)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    search_start,
  input  logic                    abs_valid,
  input  logic [NUM_PE*PIXEL-1:0] abs_in,
  output logic                    sad_valid,
  output logic [SAD_W-1:0]        sad_out,
  output logic [MV_W-1:0]         sad_mv,
  output logic                    busy,
  output logic                    done,
  output logic [SAD_W-1:0]        best_sad,
  output logic [MV_W-1:0]         best_mv
);

  localparam int unsigned TREE_W = PIXEL + $clog2(NUM_PE);
  localparam int unsigned BEAT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(ROWS - 1);
  localparam logic [MV_W-1:0]   LAST_CAND = MV_W'(NUM_CAND - 1);

  me_state_t         state, state_nxt;
  logic [BEAT_W-1:0] beat_cnt, beat_cur;
  logic [MV_W-1:0]   cand_cnt, cand_cur;
  logic              beat, beat_last, beat_final;
  logic              tree_valid;
  logic [TREE_W-1:0] tree_sum;
  logic              s1_last, s1_final;
  logic [MV_W-1:0]   s1_mv;
  logic [SAD_W-1:0]  acc, acc_sum;
  logic              s2_final;

  // A beat arriving with search_start is beat 0 of the new search, so the
  // counters are viewed as already cleared in that cycle.
  assign beat       = abs_valid && (search_start || state == ST_ACCUM);
  assign beat_cur   = search_start ? '0 : beat_cnt;
  assign cand_cur   = search_start ? '0 : cand_cnt;
  assign beat_last  = (beat_cur == LAST_BEAT);
  assign beat_final = beat_last && (cand_cur == LAST_CAND);
  assign acc_sum    = acc + SAD_W'(tree_sum);
  assign busy       = (state != ST_IDLE);

  sad_adder_tree #(
    .PIXEL (PIXEL),
    .NUM_PE(NUM_PE),
    .TREE_W(TREE_W)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .data      (abs_in),
    .data_valid(beat),
    .sum       (tree_sum),
    .sum_valid (tree_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (search_start) begin
      state_nxt = ST_ACCUM;
    end else begin
      case (state)
        ST_ACCUM: if (beat && beat_final)     state_nxt = ST_DRAIN;
        ST_DRAIN: if (sad_valid && s2_final)  state_nxt = ST_IDLE;
        default:  state_nxt = state;
      endcase
    end
  end

  // Beat counters plus the side-band tags that ride alongside the tree stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      cand_cnt <= '0;
      s1_last  <= 1'b0;
      s1_final <= 1'b0;
      s1_mv    <= '0;
    end else begin
      if (beat) begin
        beat_cnt <= beat_last ? '0 : beat_cur + 1'b1;
        cand_cnt <= beat_last ? cand_cur + 1'b1 : cand_cur;
      end else if (search_start) begin
        beat_cnt <= '0;
        cand_cnt <= '0;
      end
      s1_last  <= beat && beat_last;
      s1_final <= beat && beat_final;
      s1_mv    <= cand_cur;
    end
  end

  // Accumulator: on a candidate's last beat the SAD is emitted and the
  // accumulator restarts at zero, so the next beat starts a fresh SAD.
  // search_start drops whatever sits in the tree register from the old search.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      sad_valid <= 1'b0;
      sad_out   <= '0;
      sad_mv    <= '0;
      s2_final  <= 1'b0;
    end else if (search_start) begin
      acc       <= '0;
      sad_valid <= 1'b0;
      s2_final  <= 1'b0;
    end else begin
      sad_valid <= tree_valid && s1_last;
      s2_final  <= tree_valid && s1_final;
      if (tree_valid) begin
        if (s1_last) begin
          acc     <= '0;
          sad_out <= acc_sum;
          sad_mv  <= s1_mv;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

  // Strict less-than keeps the earliest candidate on ties.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_sad <= '1;
      best_mv  <= '0;
      done     <= 1'b0;
    end else if (search_start) begin
      best_sad <= '1;
      best_mv  <= '0;
      done     <= 1'b0;
    end else begin
      done <= sad_valid && s2_final;
      if (sad_valid && (sad_out < best_sad)) begin
        best_sad <= sad_out;
        best_mv  <= sad_mv;
      end
    end
  end

endmodule
